// File: rtl/uin_score_row.sv
// One hit-line row of the arrow display: per-lane arrival, timing grade, miss/empty-press pulses
// and a shared saturating combo counter.
//
// state | meaning
// IDLE  | lane dark, waiting for an arrow from the row below
// LIT   | arrow present, waiting for a press or expiry
// HIT   | arrow already graded, lane counts out its remaining length
module uin_score_row #(
    parameter int N_LANES = 4,
    parameter int PXL_W   = 4,
    parameter int HOLD_W  = 9,
    parameter int PERF_LO = 8,
    parameter int PERF_HI = 23,
    parameter int COMBO_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     top_row,
    input  logic [N_LANES-1:0]       row_below,
    input  logic [N_LANES-1:0]       user_press,
    input  logic [HOLD_W-1:0]        hold_len,
    output logic [N_LANES*PXL_W-1:0] pxls,
    output logic [N_LANES-1:0]       next_up,
    output logic [N_LANES-1:0]       hit_perfect,
    output logic [N_LANES-1:0]       hit_good,
    output logic [N_LANES-1:0]       empty_press,
    output logic [COMBO_W-1:0]       combo
);

    typedef enum logic [1:0] {IDLE, LIT, HIT} lane_state_t;

    localparam int SUM_W = COMBO_W + $clog2(N_LANES + 1);
    localparam logic [HOLD_W-1:0]  ONE       = HOLD_W'(1);
    localparam logic [HOLD_W-1:0]  PERF_LO_V = HOLD_W'(PERF_LO);
    localparam logic [HOLD_W-1:0]  PERF_HI_V = HOLD_W'(PERF_HI);
    localparam logic [COMBO_W-1:0] COMBO_MAX = '1;

    lane_state_t state     [N_LANES];
    lane_state_t state_nxt [N_LANES];
    logic [HOLD_W-1:0] elapsed     [N_LANES];
    logic [HOLD_W-1:0] elapsed_nxt [N_LANES];
    logic [HOLD_W-1:0] len         [N_LANES];
    logic [HOLD_W-1:0] len_nxt     [N_LANES];

    logic [N_LANES-1:0] prev;
    logic [N_LANES-1:0] press_edge;
    logic [N_LANES-1:0] at_end;
    logic [N_LANES-1:0] in_window;
    logic [N_LANES-1:0] next_up_nxt;
    logic [N_LANES-1:0] perfect_nxt;
    logic [N_LANES-1:0] good_nxt;
    logic [N_LANES-1:0] empty_nxt;
    logic [N_LANES-1:0] hits;
    logic [N_LANES*PXL_W-1:0] pxls_nxt;
    logic [COMBO_W-1:0] combo_nxt;
    logic [SUM_W-1:0]   sum;

    assign press_edge = user_press & ~prev;

    always_comb begin
        at_end    = '0;
        in_window = '0;
        for (int i = 0; i < N_LANES; i++) begin
            at_end[i]    = (elapsed[i] == len[i] - ONE);
            in_window[i] = (elapsed[i] >= PERF_LO_V) && (elapsed[i] <= PERF_HI_V);
        end
    end

    always_comb begin
        next_up_nxt = '0;
        perfect_nxt = '0;
        good_nxt    = '0;
        empty_nxt   = '0;
        pxls_nxt    = '0;
        for (int i = 0; i < N_LANES; i++) begin
            state_nxt[i]   = state[i];
            elapsed_nxt[i] = elapsed[i];
            len_nxt[i]     = len[i];
            case (state[i])
                IDLE: begin
                    // arrival takes priority; a press on the arrival edge is swallowed
                    if (row_below[i]) begin
                        state_nxt[i]   = LIT;
                        elapsed_nxt[i] = '0;
                        len_nxt[i]     = (hold_len == '0) ? ONE : hold_len;
                    end else if (press_edge[i]) begin
                        empty_nxt[i] = 1'b1;
                    end
                end
                LIT: begin
                    if (press_edge[i]) begin
                        if (in_window[i]) perfect_nxt[i] = 1'b1;
                        else              good_nxt[i]    = 1'b1;
                        if (at_end[i]) begin
                            state_nxt[i] = IDLE;
                        end else begin
                            state_nxt[i]   = HIT;
                            elapsed_nxt[i] = elapsed[i] + ONE;
                        end
                    end else if (at_end[i]) begin
                        state_nxt[i]   = IDLE;
                        next_up_nxt[i] = 1'b1;
                    end else begin
                        elapsed_nxt[i] = elapsed[i] + ONE;
                    end
                end
                HIT: begin
                    if (at_end[i]) state_nxt[i]   = IDLE;
                    else           elapsed_nxt[i] = elapsed[i] + ONE;
                end
                default: state_nxt[i] = IDLE;
            endcase
            pxls_nxt[i*PXL_W +: PXL_W] = (state_nxt[i] == LIT || !top_row) ? {PXL_W{1'b1}} : '0;
        end
    end

    always_comb begin
        hits = perfect_nxt | good_nxt;
        sum  = SUM_W'(combo);
        for (int i = 0; i < N_LANES; i++) begin
            sum = sum + SUM_W'(hits[i]);
        end
        if (|next_up_nxt || |empty_nxt)   combo_nxt = '0;
        else if (sum > SUM_W'(COMBO_MAX)) combo_nxt = COMBO_MAX;
        else                              combo_nxt = sum[COMBO_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_LANES; i++) begin
                state[i]   <= IDLE;
                elapsed[i] <= '0;
                len[i]     <= ONE;
            end
            // all ones so a button held through reset does not look like a fresh press
            prev        <= '1;
            pxls        <= '0;
            next_up     <= '0;
            hit_perfect <= '0;
            hit_good    <= '0;
            empty_press <= '0;
            combo       <= '0;
        end else begin
            for (int i = 0; i < N_LANES; i++) begin
                state[i]   <= state_nxt[i];
                elapsed[i] <= elapsed_nxt[i];
                len[i]     <= len_nxt[i];
            end
            prev        <= user_press;
            pxls        <= pxls_nxt;
            next_up     <= next_up_nxt;
            hit_perfect <= perfect_nxt;
            hit_good    <= good_nxt;
            empty_press <= empty_nxt;
            combo       <= combo_nxt;
        end
    end

endmodule

// File: tb/tb_uin_score_row.sv
// Testbench for uin_score_row: a lane model pushes expected outputs per cycle into a queue,
// each scenario task pops and compares them and adds its own targeted checks.
module tb_uin_score_row;

    logic        clk = 1'b0;
    logic        reset;
    logic        top_row;
    logic [3:0]  row_below;
    logic [3:0]  user_press;
    logic [8:0]  hold_len;
    logic [15:0] pxls;
    logic [3:0]  next_up, hit_perfect, hit_good, empty_press;
    logic [7:0]  combo;

    uin_score_row dut (
        .clk(clk), .reset(reset), .top_row(top_row), .row_below(row_below),
        .user_press(user_press), .hold_len(hold_len), .pxls(pxls), .next_up(next_up),
        .hit_perfect(hit_perfect), .hit_good(hit_good), .empty_press(empty_press), .combo(combo)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [39:0] exp_q[$];
    logic [39:0] e;

    int          m_st  [4];
    int          m_el  [4];
    int          m_len [4];
    logic [3:0]  m_prev;
    logic [15:0] m_pxls;
    logic [3:0]  m_nu, m_hp, m_hg, m_ep;
    int          m_combo;

    function automatic logic [39:0] obs();
        return {pxls, next_up, hit_perfect, hit_good, empty_press, combo};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_st[i] = 0; m_el[i] = 0; m_len[i] = 1;
        end
        m_prev = 4'hF; m_pxls = '0; m_combo = 0;
        m_nu = '0; m_hp = '0; m_hg = '0; m_ep = '0;
        exp_q.delete();
    endtask

    task automatic model_step();
        logic [3:0] pe;
        int hits;
        pe = user_press & ~m_prev;
        hits = 0;
        m_nu = '0; m_hp = '0; m_hg = '0; m_ep = '0;
        for (int i = 0; i < 4; i++) begin
            case (m_st[i])
                0: begin
                    if (row_below[i]) begin
                        m_st[i] = 1; m_el[i] = 0;
                        m_len[i] = (hold_len == 0) ? 1 : int'(hold_len);
                    end else if (pe[i]) m_ep[i] = 1'b1;
                end
                1: begin
                    if (pe[i]) begin
                        if (m_el[i] >= 8 && m_el[i] <= 23) m_hp[i] = 1'b1;
                        else m_hg[i] = 1'b1;
                        hits++;
                        if (m_el[i] == m_len[i] - 1) m_st[i] = 0;
                        else begin m_st[i] = 2; m_el[i]++; end
                    end else if (m_el[i] == m_len[i] - 1) begin
                        m_st[i] = 0; m_nu[i] = 1'b1;
                    end else m_el[i]++;
                end
                default: begin
                    if (m_el[i] == m_len[i] - 1) m_st[i] = 0;
                    else m_el[i]++;
                end
            endcase
            m_pxls[i*4 +: 4] = (m_st[i] == 1 || !top_row) ? 4'hF : 4'h0;
        end
        if (m_nu != 0 || m_ep != 0) m_combo = 0;
        else m_combo = (m_combo + hits > 255) ? 255 : m_combo + hits;
        m_prev = user_press;
    endtask

    task automatic cycle();
        model_step();
        exp_q.push_back({m_pxls, m_nu, m_hp, m_hg, m_ep, 8'(m_combo)});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        top_row = 1'b1; row_below = '0; user_press = '0; hold_len = 9'd32;
        reset = 1'b1;
        #1;
        model_reset();
        n_vec++;
        if (obs() !== 40'h0) begin
            n_err++; $display("FAIL reset_outputs got %h want 0", obs());
        end
        @(posedge clk); #1;
        reset = 1'b0;
        cycle(); e = exp_q.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL reset_idle got %h want %h", obs(), e); end
        top_row = 1'b0;
        cycle(); e = exp_q.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL idle_not_top got %h want %h", obs(), e); end
        n_vec++;
        if (pxls !== 16'hFFFF) begin n_err++; $display("FAIL idle_not_top_pxls got %h want ffff", pxls); end
        top_row = 1'b1;
        cycle(); e = exp_q.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL idle_top got %h want %h", obs(), e); end
    endtask

    task automatic test_miss();
        int lit_cnt = 0, nu_cnt = 0, nu_at = -1;
        row_below = 4'b0001;
        for (int k = 0; k <= 34; k++) begin
            cycle(); row_below = '0;
            e = exp_q.pop_front(); n_vec++;
            if (obs() !== e) begin n_err++; $display("FAIL miss_k%0d got %h want %h", k, obs(), e); end
            if (pxls[3:0] == 4'hF) lit_cnt++;
            if (next_up[0]) begin nu_cnt++; nu_at = k; end
        end
        n_vec++;
        if (lit_cnt != 32) begin n_err++; $display("FAIL miss_lit_cycles got %0d want 32", lit_cnt); end
        n_vec++;
        if (nu_cnt != 1 || nu_at != 32) begin
            n_err++; $display("FAIL miss_next_up got count %0d at %0d want 1 at 32", nu_cnt, nu_at);
        end
        n_vec++;
        if (combo !== 8'd0) begin n_err++; $display("FAIL miss_combo got %0d want 0", combo); end
    endtask

    task automatic test_perfect_hit();
        int hp_cnt = 0, hp_at = -1, nu_seen = 0;
        logic [3:0] pxl_after = 4'hx;
        row_below = 4'b0010;
        cycle(); row_below = '0;
        e = exp_q.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL perf_arrive got %h want %h", obs(), e); end
        for (int k = 1; k <= 40; k++) begin
            user_press[1] = (k >= 11 && k <= 13);
            cycle();
            e = exp_q.pop_front(); n_vec++;
            if (obs() !== e) begin n_err++; $display("FAIL perf_k%0d got %h want %h", k, obs(), e); end
            if (hit_perfect == 4'b0010) begin hp_cnt++; hp_at = k; end
            if (next_up != 0) nu_seen++;
            if (k == 12) pxl_after = pxls[7:4];
        end
        user_press = '0;
        n_vec++;
        if (hp_cnt != 1 || hp_at != 11) begin
            n_err++; $display("FAIL perf_pulse got count %0d at %0d want 1 at 11", hp_cnt, hp_at);
        end
        n_vec++;
        if (nu_seen != 0) begin n_err++; $display("FAIL perf_next_up got %0d want 0", nu_seen); end
        n_vec++;
        if (combo !== 8'd1) begin n_err++; $display("FAIL perf_combo got %0d want 1", combo); end
        n_vec++;
        if (pxl_after !== 4'h0) begin n_err++; $display("FAIL perf_pxls_after got %h want 0", pxl_after); end
    endtask

    task automatic test_good_two_lanes();
        int hg0 = 0, hg2 = 0, nu_seen = 0;
        do_reset();
        row_below = 4'b0101;
        cycle(); row_below = '0;
        e = exp_q.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL good_arrive got %h want %h", obs(), e); end
        for (int k = 1; k <= 40; k++) begin
            user_press[0] = (k == 4);
            user_press[2] = (k == 32);
            cycle();
            e = exp_q.pop_front(); n_vec++;
            if (obs() !== e) begin n_err++; $display("FAIL good_k%0d got %h want %h", k, obs(), e); end
            if (hit_good[0]) hg0++;
            if (hit_good[2]) hg2++;
            if (next_up != 0) nu_seen++;
        end
        user_press = '0;
        n_vec++;
        if (hg0 != 1 || hg2 != 1) begin
            n_err++; $display("FAIL good_pulses got lane0 %0d lane2 %0d want 1 1", hg0, hg2);
        end
        n_vec++;
        if (nu_seen != 0) begin n_err++; $display("FAIL good_next_up got %0d want 0", nu_seen); end
        n_vec++;
        if (combo !== 8'd2) begin n_err++; $display("FAIL good_combo got %0d want 2", combo); end
    endtask

    task automatic test_held_press();
        int ep_seen = 0;
        user_press = 4'b1000;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            row_below = (r == 0) ? 4'b0111 : 4'b0011;
            cycle(); row_below = '0;
            e = exp_q.pop_front(); n_vec++;
            if (obs() !== e) begin n_err++; $display("FAIL held_arrive%0d got %h want %h", r, obs(), e); end
            for (int k = 1; k <= 40; k++) begin
                user_press[2:0] = (k == 11) ? ((r == 0) ? 3'b111 : 3'b011) : 3'b000;
                cycle();
                e = exp_q.pop_front(); n_vec++;
                if (obs() !== e) begin n_err++; $display("FAIL held_r%0d_k%0d got %h want %h", r, k, obs(), e); end
                if (empty_press != 0) ep_seen++;
            end
        end
        n_vec++;
        if (ep_seen != 0) begin n_err++; $display("FAIL held_no_empty got %0d want 0", ep_seen); end
        n_vec++;
        if (combo !== 8'd5) begin n_err++; $display("FAIL held_combo_pre got %0d want 5", combo); end
        user_press = 4'b0000;
        cycle(); e = exp_q.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL held_release got %h want %h", obs(), e); end
        user_press = 4'b1000;
        cycle(); e = exp_q.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL held_press got %h want %h", obs(), e); end
        n_vec++;
        if (empty_press !== 4'b1000 || combo !== 8'd0) begin
            n_err++; $display("FAIL held_empty got ep %b combo %0d want 1000 0", empty_press, combo);
        end
        cycle(); e = exp_q.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL held_after got %h want %h", obs(), e); end
        user_press = '0;
    endtask

    task automatic test_saturation();
        user_press = '0;
        do_reset();
        hold_len = 9'd0;
        for (int r = 0; r < 65; r++) begin
            row_below = 4'hF; user_press = 4'h0;
            cycle(); e = exp_q.pop_front(); n_vec++;
            if (obs() !== e) begin n_err++; $display("FAIL sat_arrive%0d got %h want %h", r, obs(), e); end
            row_below = 4'h0; user_press = 4'hF;
            cycle(); e = exp_q.pop_front(); n_vec++;
            if (obs() !== e) begin n_err++; $display("FAIL sat_hit%0d got %h want %h", r, obs(), e); end
            if (r == 62) begin
                n_vec++;
                if (combo !== 8'd252) begin n_err++; $display("FAIL sat_252 got %0d want 252", combo); end
            end
        end
        n_vec++;
        if (combo !== 8'd255) begin n_err++; $display("FAIL sat_hold got %0d want 255", combo); end
        row_below = 4'b0011; user_press = 4'h0;
        cycle(); e = exp_q.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL sat_mix_arrive got %h want %h", obs(), e); end
        row_below = 4'h0; user_press = 4'b0010;
        cycle(); e = exp_q.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL sat_mix got %h want %h", obs(), e); end
        n_vec++;
        if (next_up !== 4'b0001 || hit_good !== 4'b0010 || combo !== 8'd0) begin
            n_err++;
            $display("FAIL sat_clear got nu %b hg %b combo %0d want 0001 0010 0", next_up, hit_good, combo);
        end
        user_press = '0;
        hold_len = 9'd32;
    endtask

    task automatic test_reset_mid();
        int nu_seen = 0;
        do_reset();
        row_below = 4'b0100;
        for (int k = 0; k <= 15; k++) begin
            cycle(); row_below = '0;
            e = exp_q.pop_front(); n_vec++;
            if (obs() !== e) begin n_err++; $display("FAIL mid_k%0d got %h want %h", k, obs(), e); end
        end
        #2 reset = 1'b1;
        #1;
        n_vec++;
        if (obs() !== 40'h0) begin n_err++; $display("FAIL mid_async got %h want 0", obs()); end
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k <= 40; k++) begin
            cycle();
            e = exp_q.pop_front(); n_vec++;
            if (obs() !== e) begin n_err++; $display("FAIL mid_post%0d got %h want %h", k, obs(), e); end
            if (next_up != 0) nu_seen++;
        end
        n_vec++;
        if (nu_seen != 0) begin n_err++; $display("FAIL mid_next_up got %0d want 0", nu_seen); end
    endtask

    initial begin
        test_reset();
        test_miss();
        test_perfect_hit();
        test_good_two_lanes();
        test_held_press();
        test_saturation();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
